// File: rtl/key_schedule_controller.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// key_schedule_rk_file
//   Round-key storage: NUM_ROUNDS+1 entries of KEY_W bits.
//   Ports:
//     clk, reset          clock, async active-high reset (clears every entry)
//     wr_en/wr_idx/wr_data single write port, index 0..NUM_ROUNDS
//     rd_addr/rd_data      combinational read; addresses above NUM_ROUNDS read 0
// ---------------------------------------------------------------------------
module key_schedule_rk_file #(
  parameter int NUM_ROUNDS = 10,
  parameter int KEY_W      = 128,
  parameter int ADDR_W     = 4,
  parameter int IDX_W      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [KEY_W-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [KEY_W-1:0]  rd_data
);

  logic [KEY_W-1:0] rk_q [0:NUM_ROUNDS];
  logic [KEY_W-1:0] rk_d [0:NUM_ROUNDS];

  always_comb begin
    for (int i = 0; i <= NUM_ROUNDS; i++) begin
      rk_d[i] = rk_q[i];
      if (wr_en && (wr_idx == IDX_W'(i))) begin
        rk_d[i] = wr_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) begin
        rk_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i <= NUM_ROUNDS; i++) begin
        rk_q[i] <= rk_d[i];
      end
    end
  end

  // Address decode rather than a direct index so out-of-range reads give 0
  // instead of an undefined array element.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i <= NUM_ROUNDS; i++) begin
      if (rd_addr == ADDR_W'(i)) begin
        rd_data = rk_q[i];
      end
    end
  end

endmodule

// ---------------------------------------------------------------------------
// key_schedule_controller
//   Drives an external one-round AES-128 key-expansion unit through all
//   rounds and stores the cipher key plus every round key.
//   Ports:
//     clk, reset           clock, async active-high reset (aborts a run)
//     start, cipher_key    expansion request; key sampled on the accepting edge
//     busy, done           busy while not IDLE; done pulses one cycle at end
//     keys_valid           stored schedule is complete
//     exp_enable           one-cycle enable to expansion unit (ISSUE)
//     exp_key_num          round number 1..NUM_ROUNDS (Rcon select)
//     exp_key_in           previous round key to expansion unit
//     exp_key_out          unit result, valid the cycle after exp_enable
//     rk_rd_addr/rk_rd_data random-access round-key read
//   Requires 2**ADDR_W > NUM_ROUNDS and NUM_ROUNDS < 16.
//
//   state | meaning
//   IDLE  | waiting for start; schedule (if any) held in storage
//   ISSUE | exp_enable high, unit sees round number and previous key
//   WAIT  | unit result registered; captured into rk[round] on exit
//   DONE  | one-cycle done pulse; keys_valid set on exit
// ---------------------------------------------------------------------------
module key_schedule_controller #(
  parameter int NUM_ROUNDS = 10,
  parameter int KEY_W      = 128,
  parameter int ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [KEY_W-1:0]  cipher_key,
  output logic              busy,
  output logic              done,
  output logic              keys_valid,
  output logic              exp_enable,
  output logic [3:0]        exp_key_num,
  output logic [KEY_W-1:0]  exp_key_in,
  input  logic [KEY_W-1:0]  exp_key_out,
  input  logic [ADDR_W-1:0] rk_rd_addr,
  output logic [KEY_W-1:0]  rk_rd_data
);

  localparam int RND_W = 4;
  localparam logic [RND_W-1:0] LAST_ROUND = RND_W'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [RND_W-1:0]   round_q, round_d;
  logic [KEY_W-1:0]   cur_key_q, cur_key_d;
  logic               keys_valid_q, keys_valid_d;

  logic               rk_we;
  logic [RND_W-1:0]   rk_wr_idx;
  logic [KEY_W-1:0]   rk_wr_data;

  // State register and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      round_q      <= '0;
      cur_key_q    <= '0;
      keys_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      round_q      <= round_d;
      cur_key_q    <= cur_key_d;
      keys_valid_q <= keys_valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  state_d = (round_q == LAST_ROUND) ? S_DONE : S_ISSUE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values and round-key writes
  always_comb begin
    round_d      = round_q;
    cur_key_d    = cur_key_q;
    keys_valid_d = keys_valid_q;
    rk_we        = 1'b0;
    rk_wr_idx    = round_q;
    rk_wr_data   = exp_key_out;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rk_we        = 1'b1;
          rk_wr_idx    = '0;
          rk_wr_data   = cipher_key;
          cur_key_d    = cipher_key;
          round_d      = RND_W'(1);
          keys_valid_d = 1'b0;
        end
      end
      S_WAIT: begin
        rk_we     = 1'b1;
        cur_key_d = exp_key_out;
        // Counter stops at the last round so it can never wrap.
        if (round_q != LAST_ROUND) begin
          round_d = round_q + RND_W'(1);
        end
      end
      S_DONE: begin
        keys_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs decoded from registers only; start has no path to any output.
  // Round number and previous key are presented through ISSUE and held in
  // WAIT so the unit may sample them late in the round.
  always_comb begin
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    exp_enable  = (state_q == S_ISSUE);
    keys_valid  = keys_valid_q;
    exp_key_num = '0;
    exp_key_in  = '0;
    if ((state_q == S_ISSUE) || (state_q == S_WAIT)) begin
      exp_key_num = round_q;
      exp_key_in  = cur_key_q;
    end
  end

  key_schedule_rk_file #(
    .NUM_ROUNDS (NUM_ROUNDS),
    .KEY_W      (KEY_W),
    .ADDR_W     (ADDR_W),
    .IDX_W      (RND_W)
  ) u_rk_file (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (rk_we),
    .wr_idx  (rk_wr_idx),
    .wr_data (rk_wr_data),
    .rd_addr (rk_rd_addr),
    .rd_data (rk_rd_data)
  );

endmodule

// File: tb/tb_key_schedule_controller.sv
`timescale 1ns/1ps
module tb_key_schedule_controller;

  localparam int N      = 10;
  localparam int KEY_W  = 128;
  localparam int ADDR_W = 4;

  localparam logic [127:0] K1      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K2      = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [KEY_W-1:0]  cipher_key = '0;
  logic              busy, done, keys_valid, exp_enable;
  logic [3:0]        exp_key_num;
  logic [KEY_W-1:0]  exp_key_in;
  logic [KEY_W-1:0]  exp_key_out = '0;
  logic [ADDR_W-1:0] rk_rd_addr;
  logic [KEY_W-1:0]  rk_rd_data;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  key_schedule_controller #(.NUM_ROUNDS(N), .KEY_W(KEY_W), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .cipher_key  (cipher_key),
    .busy        (busy),
    .done        (done),
    .keys_valid  (keys_valid),
    .exp_enable  (exp_enable),
    .exp_key_num (exp_key_num),
    .exp_key_in  (exp_key_in),
    .exp_key_out (exp_key_out),
    .rk_rd_addr  (rk_rd_addr),
    .rk_rd_data  (rk_rd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- AES-128 arithmetic ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box from the GF(2^8) inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq  = x;
    logic [7:0] inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // One-round expansion unit behaviour (external block model).
  function automatic logic [127:0] unit_round(input logic [127:0] k, input logic [3:0] num);
    logic [7:0]  rc = 8'h01;
    logic [31:0] t, w0, w1, w2, w3;
    for (int i = 1; i < int'(num); i++) rc = xtime(rc);
    t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  always @(posedge clk) begin
    if (exp_enable === 1'b1) exp_key_out <= unit_round(exp_key_in, exp_key_num);
  end

  // Reference schedule: the 44-word FIPS-197 expansion. Entries 11..15 stay 0.
  typedef logic [15:0][127:0] sched_t;

  function automatic sched_t ref_schedule(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    sched_t      s = '0;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= N; r++) s[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return s;
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    int           cyc;
    logic [3:0]   num;
    logic [127:0] kin;
  } exp_t;

  typedef struct {
    int           cyc;
    sched_t       s;
    bit           kat1_en;
    logic [127:0] kat1;
    bit           kat10_en;
    logic [127:0] kat10;
  } done_t;

  exp_t  exp_q[$];
  done_t done_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic push_run(input logic [127:0] key, input int a,
                          input bit k1e, input logic [127:0] k1,
                          input bit k10e, input logic [127:0] k10);
    sched_t s;
    exp_t   e;
    done_t  d;
    s = ref_schedule(key);
    for (int r = 1; r <= N; r++) begin
      e.cyc = a + 2*(r-1);
      e.num = 4'(r);
      e.kin = s[r-1];
      exp_q.push_back(e);
    end
    d.cyc = a + 2*N;
    d.s = s;
    d.kat1_en = k1e;
    d.kat1 = k1;
    d.kat10_en = k10e;
    d.kat10 = k10;
    done_q.push_back(d);
  endtask

  // Monitor: compares every DUT-presented event against the queues.
  initial begin : monitor
    exp_t  e;
    done_t d;
    rk_rd_addr = '0;
    forever begin
      @(negedge clk or posedge reset);
      if (reset) begin
        #0.2;
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_keys_valid", 128'(keys_valid), 128'(0));
        chk("rst_exp_enable", 128'(exp_enable), 128'(0));
        chk("rst_exp_key_num", 128'(exp_key_num), 128'(0));
        chk("rst_exp_key_in", exp_key_in, 128'(0));
        for (int a = 0; a < 16; a++) begin
          rk_rd_addr = 4'(a);
          #0.2;
          chk($sformatf("rst_rk[%0d]", a), rk_rd_data, 128'(0));
        end
      end else begin
        if (exp_enable === 1'b1) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_exp_enable: got num %0d at cycle %0d expected none", exp_key_num, cyc);
          end else begin
            e = exp_q.pop_front();
            chk("issue_cycle", 128'(cyc), 128'(e.cyc));
            chk("exp_key_num", 128'(exp_key_num), 128'(e.num));
            chk("exp_key_in", exp_key_in, e.kin);
            chk("kv_low_in_run", 128'(keys_valid), 128'(0));
            chk("busy_in_run", 128'(busy), 128'(1));
          end
        end
        if (done === 1'b1) begin
          if (done_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
          end else begin
            d = done_q.pop_front();
            chk("done_cycle", 128'(cyc), 128'(d.cyc));
            chk("kv_low_at_done", 128'(keys_valid), 128'(0));
            for (int a = 0; a < 16; a++) begin
              rk_rd_addr = 4'(a);
              #0.2;
              chk($sformatf("rk[%0d]", a), rk_rd_data, d.s[a]);
              if (d.kat1_en && a == 1) chk("kat_rk1", rk_rd_data, d.kat1);
              if (d.kat10_en && a == 10) chk("kat_rk10", rk_rd_data, d.kat10);
            end
            @(negedge clk);
            chk("kv_after_done", 128'(keys_valid), 128'(1));
            chk("idle_after_done", 128'(busy), 128'(0));
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  // x1/x2: extra start pulses at busy cycles 1..2N (0 = none).
  // hold: keep start high through DONE so the next call re-triggers.
  task automatic do_run(input logic [127:0] key, input int x1, input int x2, input bit hold,
                        input bit k1e, input logic [127:0] k1,
                        input bit k10e, input logic [127:0] k10);
    @(negedge clk);
    start = 1'b1;
    cipher_key = key;
    @(posedge clk);
    #1;
    push_run(key, cyc, k1e, k1, k10e, k10);
    for (int c = 1; c <= 2*N+1; c++) begin
      @(negedge clk);
      start = hold || (c == x1) || (c == x2);
      cipher_key = rand_key();
    end
  endtask

  task automatic abort_run(input logic [127:0] key);
    @(negedge clk);
    start = 1'b1;
    cipher_key = key;
    @(posedge clk);
    #1;
    push_run(key, cyc, 1'b0, '0, 1'b0, '0);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(posedge clk);
    #3;
    reset = 1'b1;
    exp_q.delete();
    done_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin : stimulus
    int  x1, x2;
    bit  hold;
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    gap(2);

    do_run(K1, 0, 0, 1'b0, 1'b1, K1_RK1, 1'b1, K1_RK10);
    gap(3);
    do_run(K2, 0, 0, 1'b0, 1'b0, '0, 1'b1, K2_RK10);
    gap(2);
    do_run(K1, 3, 19, 1'b0, 1'b1, K1_RK1, 1'b1, K1_RK10);
    gap(2);
    abort_run(K1);
    gap(1);
    do_run(K2, 0, 0, 1'b0, 1'b0, '0, 1'b1, K2_RK10);
    gap(2);
    do_run(K1, 0, 0, 1'b1, 1'b1, K1_RK1, 1'b1, K1_RK10);
    do_run(K2, 0, 0, 1'b0, 1'b0, '0, 1'b1, K2_RK10);
    gap(2);

    for (int i = 0; i < 6; i++) begin
      x1 = int'($urandom_range(0, 2*N));
      x2 = int'($urandom_range(1, 2*N));
      hold = (i < 5) && ($urandom_range(0, 1) == 1);
      do_run(rand_key(), x1, x2, hold, 1'b0, '0, 1'b0, '0);
      if (!hold) gap(int'($urandom_range(1, 4)));
    end

    gap(6);
    chk("exp_q_drained", 128'(exp_q.size()), 128'(0));
    chk("done_q_drained", 128'(done_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish by %0t expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
